// File: rtl/volcado_memoria_debug.sv
// Debug memory dumper: walks data memory cells 0..CELDAS-1 through the debug read port
// and streams each word MSB byte first over a valid/ready link to the debug UART.
module volcado_memoria_debug #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Inicio,
  output logic [NBITS-1:0] o_DebugDireccion,
  input  logic [NBITS-1:0] i_DebugDato,
  output logic [7:0]       o_TxDato,
  output logic             o_TxValido,
  input  logic             i_TxListo,
  output logic             o_Ocupado,
  output logic             o_Fin
);

  localparam int BYTES = NBITS / 8;
  localparam int AW    = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELDAS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SEND,
    FIN
  } state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [BW-1:0]    byte_idx;
  logic [NBITS-1:0] shift_reg;
  logic [NBITS-1:0] shifted;
  logic             accept;

  assign shifted = shift_reg << 8;
  assign accept  = o_TxValido & i_TxListo;

  // The address is loaded on the edge that enters SETUP, so the combinational
  // debug read is settled by the edge that leaves SETUP and captures the word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= IDLE;
      addr             <= '0;
      byte_idx         <= '0;
      shift_reg        <= '0;
      o_DebugDireccion <= '0;
      o_TxDato         <= '0;
      o_TxValido       <= 1'b0;
      o_Ocupado        <= 1'b0;
      o_Fin            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Inicio) begin
            state            <= SETUP;
            addr             <= '0;
            o_DebugDireccion <= '0;
            o_Ocupado        <= 1'b1;
          end
        end

        SETUP: begin
          shift_reg  <= i_DebugDato;
          o_TxDato   <= i_DebugDato[NBITS-1 -: 8];
          o_TxValido <= 1'b1;
          byte_idx   <= '0;
          state      <= SEND;
        end

        SEND: begin
          if (accept) begin
            if (byte_idx != LAST_BYTE) begin
              shift_reg <= shifted;
              o_TxDato  <= shifted[NBITS-1 -: 8];
              byte_idx  <= byte_idx + BW'(1);
            end else begin
              o_TxValido <= 1'b0;
              if (addr != LAST_ADDR) begin
                addr             <= addr + AW'(1);
                o_DebugDireccion <= NBITS'(addr + AW'(1));
                state            <= SETUP;
              end else begin
                o_Fin <= 1'b1;
                state <= FIN;
              end
            end
          end
        end

        FIN: begin
          o_Fin     <= 1'b0;
          o_Ocupado <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_volcado_memoria_debug.sv
// Directed bench for volcado_memoria_debug: 32-bit/16-cell instance plus a 16-bit/4-cell
// instance, each backed by a memory whose cell k holds 2*k.
module tb_volcado_memoria_debug;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio, listo;
  logic [31:0] dir, dato;
  logic [7:0]  tx_dato;
  logic        tx_valido, ocupado, fin;

  logic        inicio_b, listo_b;
  logic [15:0] dir_b, dato_b;
  logic [7:0]  tx_dato_b;
  logic        tx_valido_b, ocupado_b, fin_b;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  lfsr = 8'hA5;

  always #5 clk = ~clk;

  assign dato   = (dir < 32'd16) ? (dir << 1) : 32'd0;
  assign dato_b = (dir_b < 16'd4) ? (dir_b << 1) : 16'd0;

  volcado_memoria_debug #(.NBITS(32), .CELDAS(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_Inicio(inicio),
    .o_DebugDireccion(dir), .i_DebugDato(dato),
    .o_TxDato(tx_dato), .o_TxValido(tx_valido), .i_TxListo(listo),
    .o_Ocupado(ocupado), .o_Fin(fin)
  );

  volcado_memoria_debug #(.NBITS(16), .CELDAS(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_Inicio(inicio_b),
    .o_DebugDireccion(dir_b), .i_DebugDato(dato_b),
    .o_TxDato(tx_dato_b), .o_TxValido(tx_valido_b), .i_TxListo(listo_b),
    .o_Ocupado(ocupado_b), .o_Fin(fin_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ini, input logic rdy);
    inicio = ini;
    listo  = rdy;
  endtask

  // Byte n of the full dump: cell n/4, MSB first.
  function automatic logic [7:0] exp_byte(input int n);
    logic [31:0] w;
    w = 32'(2 * (n / 4));
    return w[31 - 8 * (n % 4) -: 8];
  endfunction

  // mode 0: ready always high; mode 1: ready from an LFSR.
  task automatic run_dump(input int mode, input int pulse_cycle, input bit hold);
    int   nbytes, fin_count, fin_cycle, exit_cycle;
    bit   expect_setup, prev_hold, done;
    logic [7:0] prev_dato;
    nbytes = 0; fin_count = 0; fin_cycle = 0; exit_cycle = 0;
    expect_setup = 1; prev_hold = 0; done = 0; prev_dato = '0;
    @(negedge clk) applyStimulus(1'b1, 1'b1);
    @(posedge clk); #1;
    if (!hold) inicio = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (fin_count > 0 && !ocupado) begin
        done = 1;
        exit_cycle = c;
        break;
      end
      if (pulse_cycle != 0) begin
        if (c == pulse_cycle) inicio = 1'b1;
        if (c == pulse_cycle + 1) inicio = 1'b0;
      end
      if (mode == 0) listo = 1'b1;
      else begin
        lfsr  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        listo = lfsr[0];
      end
      if (prev_hold) begin
        checkOutput("hold_valid", {31'd0, tx_valido}, 32'd1);
        checkOutput("hold_byte", {24'd0, tx_dato}, {24'd0, prev_dato});
      end
      if (expect_setup) begin
        checkOutput("setup_addr", dir, nbytes / 4);
        checkOutput("setup_valid", {31'd0, tx_valido}, 32'd0);
        expect_setup = 0;
      end
      if (tx_valido) checkOutput("send_addr", dir, nbytes / 4);
      if (fin) begin
        fin_count++;
        fin_cycle = c;
        checkOutput("fin_valid", {31'd0, tx_valido}, 32'd0);
        checkOutput("fin_busy", {31'd0, ocupado}, 32'd1);
      end
      if (tx_valido && listo) begin
        if (nbytes < 64) checkOutput("byte", {24'd0, tx_dato}, {24'd0, exp_byte(nbytes)});
        else checkOutput("extra_byte", nbytes, 32'd63);
        if (nbytes % 4 == 3 && nbytes < 63) expect_setup = 1;
        nbytes++;
      end
      prev_hold = tx_valido && !listo;
      prev_dato = tx_dato;
      @(posedge clk); #1;
    end
    if (!done) checkOutput("timeout", 32'd0, 32'd1);
    checkOutput("byte_total", nbytes, 32'd64);
    checkOutput("fin_count", fin_count, 32'd1);
    checkOutput("busy_fall", exit_cycle, fin_cycle + 1);
    if (mode == 0) checkOutput("fin_cycle", fin_cycle, 32'd81);
  endtask

  initial begin
    logic [7:0] exp_b [8];
    int nb, fin_cycle_b, fin_count_b;
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h06};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    inicio_b = 1'b0;
    listo_b  = 1'b0;
    #12;
    checkOutput("rst_dir", dir, 32'd0);
    checkOutput("rst_dato", {24'd0, tx_dato}, 32'd0);
    checkOutput("rst_valid", {31'd0, tx_valido}, 32'd0);
    checkOutput("rst_busy", {31'd0, ocupado}, 32'd0);
    checkOutput("rst_fin", {31'd0, fin}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Ready high while idle must not produce anything.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_valid", {31'd0, tx_valido}, 32'd0);
    checkOutput("idle_busy", {31'd0, ocupado}, 32'd0);
    checkOutput("idle_valid_b", {31'd0, tx_valido_b}, 32'd0);

    $display("[TB] full dump, ready always high");
    run_dump(0, 0, 1'b0);

    $display("[TB] full dump, pseudo-random ready");
    run_dump(1, 0, 1'b0);

    $display("[TB] start pulse during cell 3 ignored");
    run_dump(0, 18, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_second_busy", {31'd0, ocupado}, 32'd0);
    checkOutput("no_second_valid", {31'd0, tx_valido}, 32'd0);

    $display("[TB] start held through FIN restarts next cycle");
    run_dump(0, 0, 1'b1);
    @(posedge clk); #1;
    checkOutput("restart_busy", {31'd0, ocupado}, 32'd1);
    checkOutput("restart_addr", dir, 32'd0);
    inicio = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    $display("[TB] reset during byte 2 of cell 5");
    @(negedge clk) applyStimulus(1'b1, 1'b1);
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    checkOutput("mid_addr", dir, 32'd5);
    checkOutput("mid_valid", {31'd0, tx_valido}, 32'd1);
    checkOutput("mid_byte", {24'd0, tx_dato}, {24'd0, exp_byte(22)});
    rst = 1'b1;
    #1;
    checkOutput("abort_dir", dir, 32'd0);
    checkOutput("abort_dato", {24'd0, tx_dato}, 32'd0);
    checkOutput("abort_valid", {31'd0, tx_valido}, 32'd0);
    checkOutput("abort_busy", {31'd0, ocupado}, 32'd0);
    checkOutput("abort_fin", {31'd0, fin}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("after_abort_valid", {31'd0, tx_valido}, 32'd0);
    run_dump(0, 0, 1'b0);

    $display("[TB] 16-bit / 4-cell instance");
    nb = 0; fin_cycle_b = 0; fin_count_b = 0;
    @(negedge clk) begin inicio_b = 1'b1; listo_b = 1'b1; end
    @(posedge clk); #1;
    inicio_b = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (fin_b) begin
        fin_count_b++;
        fin_cycle_b = c;
      end
      if (tx_valido_b && listo_b) begin
        if (nb < 8) checkOutput("byte_b", {24'd0, tx_dato_b}, {24'd0, exp_b[nb]});
        else checkOutput("extra_byte_b", nb, 32'd7);
        nb++;
      end
      @(posedge clk); #1;
    end
    checkOutput("byte_total_b", nb, 32'd8);
    checkOutput("fin_count_b", fin_count_b, 32'd1);
    checkOutput("fin_cycle_b", fin_cycle_b, 32'd13);
    checkOutput("end_busy_b", {31'd0, ocupado_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
